// File: rtl/palette_bank_lut_if.sv
// Avalon-MM bus bundle for the palette LUT.
//   AVL_WRITE/AVL_READ  : strobes, qualified by the slave's waitrequest
//   AVL_ADDR            : {palette, index}
//   AVL_WRITEDATA       : {r,g,b} to store
//   AVL_READDATA        : {r,g,b}, valid the cycle after an accepted read
//   AVL_WAITREQUEST     : slave is busy (clearing) and ignores strobes
interface palette_bank_lut_if #(
    parameter int AW = 10,
    parameter int DW = 12
);
    logic          AVL_WRITE;
    logic          AVL_READ;
    logic [AW-1:0] AVL_ADDR;
    logic [DW-1:0] AVL_WRITEDATA;
    logic [DW-1:0] AVL_READDATA;
    logic          AVL_WAITREQUEST;

    modport master (
        output AVL_WRITE, AVL_READ, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA, AVL_WAITREQUEST
    );
    modport slave (
        input  AVL_WRITE, AVL_READ, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA, AVL_WAITREQUEST
    );
endinterface

// File: rtl/palette_bank_lut.sv
// Writable multi-bank colour palette LUT.
// NUM_PAL palettes of 2^INDEX_W {r,g,b} entries in a dual-port RAM. Port A
// serves the Avalon slave (and the post-reset clear), port B serves the
// pixel pipeline with a fixed two-cycle latency. Logical palettes are
// rotated by a frame-synchronous offset for palette animation.
// Ports:
//   CLK, RESET_N     : clock, async active-low reset
//   avl              : Avalon-MM slave (palette_bank_lut_if.slave)
//   pix_valid/index/pal : pixel request (logical palette)
//   frame_start      : vblank pulse, loads bank_rot into the rotation reg
//   bank_rot         : requested rotation offset
//   red/green/blue   : colour of the request issued two cycles earlier
//   pix_valid_out    : pix_valid delayed two cycles
//   transparent      : request hit the transparency key
//   init_done        : RAM clear finished
module palette_bank_lut #(
    parameter int INDEX_W      = 8,
    parameter int COLOR_W      = 4,
    parameter int NUM_PAL      = 4,
    parameter int TRANSP_INDEX = 0,
    parameter int TRANSP_EN    = 1
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    palette_bank_lut_if.slave          avl,
    input  logic                       pix_valid,
    input  logic [INDEX_W-1:0]         pix_index,
    input  logic [$clog2(NUM_PAL)-1:0] pix_pal,
    input  logic                       frame_start,
    input  logic [$clog2(NUM_PAL)-1:0] bank_rot,
    output logic [COLOR_W-1:0]         red,
    output logic [COLOR_W-1:0]         green,
    output logic [COLOR_W-1:0]         blue,
    output logic                       pix_valid_out,
    output logic                       transparent,
    output logic                       init_done
);
    localparam int PW    = $clog2(NUM_PAL);
    localparam int AW    = PW + INDEX_W;
    localparam int DW    = 3 * COLOR_W;
    localparam int DEPTH = NUM_PAL << INDEX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_addr;
    logic            r_init_done;
    logic [PW-1:0]   r_rot;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_pix_q;
    logic [DW-1:0]   r_rdata;
    logic [2:1]      r_vld_pipe;
    logic            r_s1_transp;
    logic            r_s1_init;
    logic [DW-1:0]   r_rgb;
    logic            r_transp;

    logic            w_init;
    logic            w_bus_wr;
    logic            w_bus_rd;
    logic [PW-1:0]   w_phys_pal;
    logic [AW-1:0]   w_pix_addr;
    logic            w_transp;

    assign w_init     = (r_state == ST_INIT);
    assign w_bus_wr   = avl.AVL_WRITE & ~w_init;
    assign w_bus_rd   = avl.AVL_READ & ~w_init;
    // PW-bit add: the wrap modulo NUM_PAL is the natural overflow.
    assign w_phys_pal = pix_pal + r_rot;
    assign w_pix_addr = {w_phys_pal, pix_index};
    assign w_transp   = (TRANSP_EN != 0) && (pix_index == INDEX_W'(TRANSP_INDEX));

    // Clear sequencer: one zero write per cycle over the whole RAM.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_INIT;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) r_state <= ST_RUN;
                end
                ST_RUN:  r_init_done <= 1'b1;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // RAM: port A writes (clear or bus), port B pixel read. Both reads see
    // pre-edge contents, so a same-cycle write is visible one cycle later.
    always_ff @(posedge CLK) begin
        if (w_init)        r_mem[r_clr_addr]   <= '0;
        else if (w_bus_wr) r_mem[avl.AVL_ADDR] <= avl.AVL_WRITEDATA;
        r_pix_q <= r_mem[w_pix_addr];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)      r_rdata <= '0;
        else if (w_bus_rd) r_rdata <= r_mem[avl.AVL_ADDR];
    end

    // Rotation takes effect for pixels issued after the frame_start cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)         r_rot <= '0;
        else if (frame_start) r_rot <= bank_rot;
    end

    // Pixel pipeline. Init status travels with the request so a pixel
    // issued during the clear comes out black and opaque.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vld_pipe  <= '0;
            r_s1_transp <= 1'b0;
            r_s1_init   <= 1'b0;
            r_rgb       <= '0;
            r_transp    <= 1'b0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[1], pix_valid};
            r_s1_transp <= w_transp;
            r_s1_init   <= w_init;
            if (r_vld_pipe[1]) begin
                r_rgb    <= r_s1_init ? '0 : r_pix_q;
                r_transp <= r_s1_transp & ~r_s1_init;
            end
        end
    end

    assign avl.AVL_READDATA    = r_rdata;
    assign avl.AVL_WAITREQUEST = w_init;
    assign red           = r_rgb[DW-1 -: COLOR_W];
    assign green         = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign blue          = r_rgb[COLOR_W-1:0];
    assign pix_valid_out = r_vld_pipe[2];
    assign transparent   = r_transp;
    assign init_done     = r_init_done;
endmodule

// File: doc/palette_bank_lut.md
Name: palette_bank_lut

Overview:
Writable, multi-bank successor to the fixed per-sprite palette ROMs. It holds NUM_PAL palettes of 2^INDEX_W RGB entries in dual-port RAM. The pixel pipeline reads it with fixed latency, and the Avalon-MM slave writes and reads it. It also provides frame-synchronous bank rotation for palette animation, transparency-key flagging, and a self-clearing init sequence after reset. It sits between the sprite/turret ROM index outputs and the VGA colour mux.

Parameters:
INDEX_W, 8, colour index width; entries per palette = 2^INDEX_W
COLOR_W, 4, bits per colour channel
NUM_PAL, 4, number of palettes (power of 2, >=2)
TRANSP_INDEX, 0, index flagged transparent
TRANSP_EN, 1, 1 enables transparency flag; 0 ties it low

Ports:
CLK  in  1  single clock
RESET_N  in  1  asynchronous, active-low reset
AVL_WRITE  in  1  bus write strobe
AVL_READ  in  1  bus read strobe
AVL_ADDR  in  PW+INDEX_W  {palette, index}; PW = log2(NUM_PAL)
AVL_WRITEDATA  in  3*COLOR_W  {r,g,b}
AVL_READDATA  out  3*COLOR_W  read data, valid 1 cycle after AVL_READ
AVL_WAITREQUEST  out  1  high while init runs
pix_valid  in  1  pixel request qualifier
pix_index  in  INDEX_W  colour index
pix_pal  in  PW  logical palette select
frame_start  in  1  one-cycle pulse at start of vblank
bank_rot  in  PW  requested rotation offset
red/green/blue  out  COLOR_W each  colour output
pix_valid_out  out  1  pix_valid delayed 2 cycles
transparent  out  1  entry equals transparency key
init_done  out  1  high once clear completes

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, rot_reg=0, FSM=INIT, clear counter=0.
- FSM INIT: writes 0 to address counter each cycle, NUM_PAL*2^INDEX_W cycles. Then goes to RUN and init_done=1 on the following cycle. In INIT: AVL_WAITREQUEST=1 and bus writes/reads are ignored. pix_valid_out still pipelines, but rgb is forced 0 and transparent=0.
- FSM RUN: stays until reset. A reset mid-INIT or mid-RUN restarts INIT from address 0.
- Physical palette = (pix_pal + rot_reg) mod NUM_PAL; the wrap is natural PW-bit overflow.
- rot_reg loads bank_rot only in a cycle with frame_start=1. A bank_rot change without frame_start has no effect.
- Pixel path, 2-cycle latency:
  - Stage 1 registers the address, the TRANSP flag (pix_index==TRANSP_INDEX and TRANSP_EN) and valid.
  - Stage 2 registers the RAM output to rgb.
  - Input at cycle n appears at cycle n+2. When pix_valid_out=0, rgb holds its previous value.
- Bus port:
  - Write commits at the clock edge.
  - Read returns data the next cycle and AVL_READDATA holds until the next read.
  - AVL_WRITE and AVL_READ together: the write takes effect and the read returns the old data.
- Collision: a pixel read and a bus write to the same address in the same cycle give the pixel old data; the new data is visible from the next request.
- frame_start in the same cycle as pix_valid: that pixel uses the old rot_reg, and later pixels use the new one.
- Index boundaries 0 and 2^INDEX_W-1 and palette NUM_PAL-1 are fully addressable, with no aliasing.

Test Plan:
- Reset, then idle -> init_done rises after 1024+1 cycles (defaults). AVL_WAITREQUEST=1 throughout. Any pixel read during init yields rgb=0.
- Write {pal1,idx 0x05}=12'hA3C, then pixel idx5 pal1, rot 0 -> rgb=A/3/C exactly 2 cycles later, with pix_valid_out=1.
- bank_rot=3 with no frame_start; pixel pal2 idx5 -> reads physical pal2. Pulse frame_start, repeat -> reads physical pal1 ((2+3) mod 4), returning A3C.
- Pixel idx 0 with TRANSP_EN=1 -> transparent=1. Idx 1 -> 0. With TRANSP_EN=0, idx 0 -> 0.
- Same-cycle bus write 12'hFFF and pixel read of {pal0,idx 0xFF} (old 000) -> pixel gets 000, the next read gets FFF. Bus read of the same address next cycle returns FFF.
- Assert RESET_N low mid-RUN -> outputs 0 immediately. After release, INIT reruns and previously written entries read back 000.
